// File: rtl/uni2bi_pkg.sv
// Shared types and defaults for the unipolar-to-bipolar frame sequencer.
package uni2bi_pkg;

    localparam int unsigned CNT_W_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/uni2bi_core.sv
// Conversion datapath: a one-bit carry accumulator that adds (in_bit + 1)
// each consumed cycle and emits the overflow as the bipolar stream bit.
module uni2bi_core
    import uni2bi_pkg::*;
(
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    input  logic in_bit_i,
    output logic nextBit_o,
    output logic out_bit_o,
    output logic out_valid_o
);

    logic       carry_q, carry_d;
    logic       outBit_q, outBit_d;
    logic       outValid_q;
    logic [1:0] sum;

    // Form carry + in_bit + 1 and pick the next carry/out bit; clear wins.
    always_comb begin
        sum      = {1'b0, carry_q} + {1'b0, in_bit_i} + 2'd1;
        carry_d  = carry_q;
        outBit_d = outBit_q;
        if (clr_i) begin
            carry_d = 1'b0;
        end else if (en_i) begin
            carry_d  = sum[0];
            outBit_d = sum[1];
        end
    end

    // Carry and registered output; out_valid follows a consume by one cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            carry_q    <= 1'b0;
            outBit_q   <= 1'b0;
            outValid_q <= 1'b0;
        end else begin
            carry_q    <= carry_d;
            outBit_q   <= outBit_d;
            outValid_q <= en_i;
        end
    end

    assign nextBit_o   = sum[1];
    assign out_bit_o   = outBit_q;
    assign out_valid_o = outValid_q;

endmodule

// File: rtl/uni2bi_frame_ctrl.sv
// Frame sequencer: accepts a start with a length, streams exactly that many
// valid bits through uni2bi_core, counts ones and pulses done at the end.
module uni2bi_frame_ctrl
    import uni2bi_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [CNT_W-1:0] frame_len_i,
    input  logic             abort_i,
    input  logic             in_bit_i,
    input  logic             in_valid_i,
    output logic             out_bit_o,
    output logic             out_valid_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [CNT_W-1:0] in_ones_o,
    output logic [CNT_W-1:0] out_ones_o
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] remain_q, remain_d;
    logic [CNT_W-1:0] inOnes_q, inOnes_d;
    logic [CNT_W-1:0] outOnes_q, outOnes_d;
    logic             startAcc;
    logic             consume;
    logic             nextBit;

    // Next-state logic; abort overrides both start acceptance and consumption.
    always_comb begin
        state_d  = state_q;
        startAcc = 1'b0;
        consume  = 1'b0;
        if (abort_i) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE, DONE: begin
                    if (start_i) begin
                        startAcc = 1'b1;
                        state_d  = (frame_len_i != '0) ? RUN : DONE;
                    end else begin
                        state_d = IDLE;
                    end
                end
                RUN: begin
                    if (in_valid_i) begin
                        consume = 1'b1;
                        if (remain_q == CNT_W'(1)) begin
                            state_d = DONE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Remaining-bit and ones counters: cleared on start, stepped per consume.
    always_comb begin
        remain_d  = remain_q;
        inOnes_d  = inOnes_q;
        outOnes_d = outOnes_q;
        if (startAcc) begin
            remain_d  = frame_len_i;
            inOnes_d  = '0;
            outOnes_d = '0;
        end else if (consume) begin
            remain_d  = remain_q - CNT_W'(1);
            inOnes_d  = inOnes_q + CNT_W'(in_bit_i);
            outOnes_d = outOnes_q + CNT_W'(nextBit);
        end
    end

    // State and counter registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            remain_q  <= '0;
            inOnes_q  <= '0;
            outOnes_q <= '0;
        end else begin
            state_q   <= state_d;
            remain_q  <= remain_d;
            inOnes_q  <= inOnes_d;
            outOnes_q <= outOnes_d;
        end
    end

    uni2bi_core u_core (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .clr_i       (startAcc),
        .en_i        (consume),
        .in_bit_i    (in_bit_i),
        .nextBit_o   (nextBit),
        .out_bit_o   (out_bit_o),
        .out_valid_o (out_valid_o)
    );

    assign busy_o     = (state_q == RUN);
    assign done_o     = (state_q == DONE);
    assign in_ones_o  = inOnes_q;
    assign out_ones_o = outOnes_q;

endmodule
